// File: rtl/led_shift_tx_pkg.sv
// Types and defaults for the serial LED transmitter; encodings come from the shared defs file.
package led_shift_tx_pkg;

`include "led_serial_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE  = `LED_ST_IDLE,
        ST_LOW   = `LED_ST_LOW,
        ST_HIGH  = `LED_ST_HIGH,
        ST_LATCH = `LED_ST_LATCH
    } led_state_e;

    localparam int DEF_WIDTH   = `LED_DEF_WIDTH;
    localparam int DEF_CLK_DIV = `LED_DEF_CLK_DIV;

    // Counter width able to hold 0..n without wrapping.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_serial_defs.vh
// Constants shared by the serial LED transmitter and any future receiver/driver model.
`ifndef LED_SERIAL_DEFS_VH
`define LED_SERIAL_DEFS_VH

`define LED_ST_IDLE     2'd0
`define LED_ST_LOW      2'd1
`define LED_ST_HIGH     2'd2
`define LED_ST_LATCH    2'd3

`define LED_DEF_WIDTH   8
`define LED_DEF_CLK_DIV 4

`endif

// File: rtl/led_shift_tx_phase_timer.sv
// Phase-length timer: counts CLK_DIV cycles while run_i is high, pulses expire_o on the last one.
// Counter returns to 0 on expiry, on restart_i and whenever idle, so each timed state starts fresh.
module led_shift_tx_phase_timer
    import led_shift_tx_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic restart_i,
    output logic expire_o
);

    localparam int             CW   = cnt_bits(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign expire_o = run_i && (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (restart_i || !run_i || expire_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_tx.sv
// Parallel-in serial-out LED link transmitter (sclk/sdata/latch) for a 74HC595-style driver.
// Frame takes (2*WIDTH+1)*CLK_DIV cycles after handshake; load_ready is low for the whole frame.
module led_shift_tx
    import led_shift_tx_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = cnt_bits(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    led_state_e       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BW-1:0]    bit_cnt_q;
    logic             sclk_q;
    logic             sdata_q;
    logic             latch_q;
    logic             busy_q;
    logic             done_q;

    logic             handshake;
    logic             phase_exp;
    logic             first_bit;
    logic             next_bit;

    assign load_ready = (state_q == ST_IDLE);
    assign handshake  = load_valid && load_ready;

    // Output end of the shift register depends on bit order; next_bit is what follows the shift.
    always_comb begin
        shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
        next_bit  = MSB_FIRST ? shreg_q[WIDTH-2]   : shreg_q[1];
    end

    led_shift_tx_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .run_i     (state_q != ST_IDLE),
        .restart_i (handshake),
        .expire_o  (phase_exp)
    );

    // Outputs are set on the transition into each state so they line up with it cycle-for-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (handshake) begin
                        shreg_q   <= load_data;
                        bit_cnt_q <= '0;
                        sdata_q   <= first_bit;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (phase_exp) begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_exp) begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        sclk_q    <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            latch_q <= 1'b1;
                            state_q <= ST_LATCH;
                        end else begin
                            sdata_q <= next_bit;
                            state_q <= ST_LOW;
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_exp) begin
                        latch_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign latch = latch_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
